wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus-cycle limit in clocks (1..65535).
REQ-002 SHALL have port wb_clk_i, input, width 1: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port wb_rst_i, input, width 1: reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid_i, input, width 1: a command is offered.
REQ-005 SHALL have port cmd_ready_o, output, width 1: the block accepts a command.
REQ-006 SHALL have port cmd_we_i, input, width 1: 1 = write, 0 = read.
REQ-007 SHALL have ports cmd_adr_i (input, width 32) and cmd_dat_i (input, width 32): command address and write data.
REQ-008 SHALL have port cmd_sel_i, input, width 4: byte selects.
REQ-009 SHALL have port rsp_valid_o, output, width 1: a response is present.
REQ-010 SHALL have port rsp_ready_i, input, width 1: the response is consumed.
REQ-011 SHALL have port rsp_dat_o, output, width 32: read data.
REQ-012 SHALL have port rsp_err_o, output, width 1: the transaction timed out.
REQ-013 SHALL have outputs wbm_cyc_o (1), wbm_stb_o (1), wbm_we_o (1), wbm_sel_o (4), wbm_adr_o (32) and wbm_dat_o (32): the Wishbone master request.
REQ-014 SHALL have inputs wbm_ack_i (1) and wbm_dat_i (32): the Wishbone slave response.
REQ-015 SHALL have port busy_o, output, width 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> BUS -> RESP -> IDLE, with all outputs registered.
REQ-017 SHALL drive cmd_ready_o high only in IDLE, and SHALL capture we/adr/dat/sel into registers on cmd_valid_i && cmd_ready_o, going to BUS.
REQ-018 SHALL, in BUS, hold wbm_cyc_o = wbm_stb_o = 1 with wbm_we_o/sel/adr/dat stable at the captured values for the whole cycle.
REQ-019 SHALL, on an edge with wbm_ack_i = 1 in BUS: deassert cyc/stb after that edge; set rsp_dat_o = wbm_dat_i for reads (32'h0 for writes); set rsp_err_o = 0; go to RESP.
REQ-020 SHALL hold rsp_valid_o high in RESP, with data stable, until an edge with rsp_ready_i = 1, then go to IDLE.
REQ-021 SHALL meet this latency with a zero-wait slave: command at edge E0, cyc/stb high E0..E1, ack sampled at E1, rsp_valid_o high after E1, so at most one transaction every 3 clocks.
REQ-022 SHALL ignore wbm_ack_i outside BUS.
REQ-023 SHALL leave cmd_valid_i unacknowledged while not IDLE, with no queuing.
REQ-024 SHALL issue cmd_sel_i = 4'b0000 unchanged on the bus.
REQ-025 SHALL drive wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o to 0 while cyc is low.

Reset
REQ-026 SHALL, on wb_rst_i = 1 at an edge, enter IDLE and drive: cmd_ready_o = 1 after release, rsp_valid_o = 0, rsp_err_o = 0, rsp_dat_o = 0, all wbm_* outputs = 0, busy_o = 0, timeout count = 0.
REQ-027 SHALL, on reset mid-transaction (BUS or RESP), drop cyc/stb after that edge and emit no response.

Configuration
REQ-028 SHALL, with macro WB_INITIATOR_TIMEOUT_EN defined: count clocks in BUS (cleared on entry), and when TIMEOUT_CYCLES clocks pass without ack, drop cyc/stb and go to RESP with rsp_err_o = 1 and rsp_dat_o = 32'h0.
REQ-029 SHALL, when ack and timeout terminal count occur on the same edge, let ack win (rsp_err_o = 0).
REQ-030 SHALL, with WB_INITIATOR_TIMEOUT_EN undefined: have no counter, wait in BUS indefinitely, and tie rsp_err_o to 0.

Structure
REQ-031 SHALL place the FSM state encodings (IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2) and the 32'h0 error-data constant in the shared package/include used by the user_proj blocks.
REQ-032 SHALL implement the timeout counter as sub-module wb_timeout_ctr (clear, enable, terminal-count output), instantiated only under WB_INITIATOR_TIMEOUT_EN.

Verification
REQ-033 SHALL cover a write: cmd we = 1, adr 32'h3000_0000, dat 32'h0000_00A5, sel 4'hF; slave acks 1 clock later -> wbm_dat_o = 32'hA5 during cyc, rsp_err_o = 0, cyc high exactly 1 clock.
REQ-034 SHALL cover a read: slave returns 32'h1234_5678 after 3 wait states -> rsp_dat_o = 32'h1234_5678, cyc high 4 clocks, rsp_valid held while rsp_ready_i = 0 for 5 clocks.
REQ-035 SHALL cover back-to-back commands with cmd_valid_i held high and a zero-wait slave -> 3 clocks per transaction; cmd_ready_o low in BUS/RESP.
REQ-036 SHALL cover timeout (macro on, TIMEOUT_CYCLES = 8): no ack -> cyc drops after 8 clocks, rsp_err_o = 1, rsp_dat_o = 0; an ack on clock 8 instead -> rsp_err_o = 0.
REQ-037 SHALL cover reset asserted on the 2nd clock of BUS -> cyc/stb = 0 the next clock, rsp_valid_o never asserts, cmd_ready_o = 1 after release.
REQ-038 SHALL cover a stray wbm_ack_i pulse in IDLE -> no state change, no response.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// ============================================================================
// Module      : wb_initiator_pkg
// Description : Shared state encodings and constants for the Wishbone
//               command initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Read data returned with an error (timed-out) response
    localparam logic [31:0] c_err_data = 32'h0;

    localparam int unsigned c_tmo_w = 16;

endpackage : wb_initiator_pkg

`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
// ============================================================================
// Module      : wb_timeout_ctr
// Description : Bus-cycle watchdog counter with clear, enable and a
//               terminal-count flag at LIMIT enabled clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_ctr
    import wb_initiator_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [c_tmo_w-1:0] r_cnt_q;
    logic [c_tmo_w-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    // Count holds the number of already-elapsed clocks, so the LIMIT-th edge
    // is the one seen while the count equals LIMIT-1.
    assign o_tc = i_en && (r_cnt_q == c_tmo_w'(LIMIT - 1));

endmodule : wb_timeout_ctr

`default_nettype wire

// File: rtl/wb_initiator.sv
// ============================================================================
// Module      : wb_initiator
// Description : Single-outstanding Wishbone master driven by a valid/ready
//               command port, returning data on a valid/ready response port.
//               Optional bus watchdog enabled by macro WB_INITIATOR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,

    output logic        busy_o
);

    state_e      r_state_q,     w_state_d;
    logic        r_cmd_ready_q, w_cmd_ready_d;
    logic        r_busy_q,      w_busy_d;
    logic        r_cyc_q,       w_cyc_d;
    logic        r_we_q,        w_we_d;
    logic [3:0]  r_sel_q,       w_sel_d;
    logic [31:0] r_adr_q,       w_adr_d;
    logic [31:0] r_dat_q,       w_dat_d;
    logic        r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0] r_rsp_dat_q,   w_rsp_dat_d;
    logic        r_rsp_err_q,   w_rsp_err_d;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic w_tmo_tc;

    // Held clear outside BUS, so every bus cycle starts counting from zero
    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .i_clr (r_state_q != ST_BUS),
        .i_en  (r_state_q == ST_BUS),
        .o_tc  (w_tmo_tc)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_cmd_ready_d = r_cmd_ready_q;
        w_busy_d      = r_busy_q;
        w_cyc_d       = r_cyc_q;
        w_we_d        = r_we_q;
        w_sel_d       = r_sel_q;
        w_adr_d       = r_adr_q;
        w_dat_d       = r_dat_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_dat_d   = r_rsp_dat_q;
        w_rsp_err_d   = r_rsp_err_q;

        case (r_state_q)
            ST_IDLE: begin
                if (cmd_valid_i && r_cmd_ready_q) begin
                    w_state_d     = ST_BUS;
                    w_cmd_ready_d = 1'b0;
                    w_busy_d      = 1'b1;
                    w_cyc_d       = 1'b1;
                    w_we_d        = cmd_we_i;
                    w_sel_d       = cmd_sel_i;
                    w_adr_d       = cmd_adr_i;
                    w_dat_d       = cmd_dat_i;
                end
            end

            ST_BUS: begin
                if (wbm_ack_i) begin
                    w_state_d     = ST_RESP;
                    w_cyc_d       = 1'b0;
                    w_we_d        = 1'b0;
                    w_sel_d       = 4'h0;
                    w_adr_d       = 32'h0;
                    w_dat_d       = 32'h0;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_dat_d   = r_we_q ? 32'h0 : wbm_dat_i;
                    w_rsp_err_d   = 1'b0;
                end
`ifdef WB_INITIATOR_TIMEOUT_EN
                // Ack takes priority when it lands on the terminal-count edge
                else if (w_tmo_tc) begin
                    w_state_d     = ST_RESP;
                    w_cyc_d       = 1'b0;
                    w_we_d        = 1'b0;
                    w_sel_d       = 4'h0;
                    w_adr_d       = 32'h0;
                    w_dat_d       = 32'h0;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_dat_d   = c_err_data;
                    w_rsp_err_d   = 1'b1;
                end
`endif
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_d     = ST_IDLE;
                    w_rsp_valid_d = 1'b0;
                    w_cmd_ready_d = 1'b1;
                    w_busy_d      = 1'b0;
                end
            end

            default: begin
                w_state_d     = ST_IDLE;
                w_cmd_ready_d = 1'b1;
                w_busy_d      = 1'b0;
                w_cyc_d       = 1'b0;
                w_we_d        = 1'b0;
                w_sel_d       = 4'h0;
                w_adr_d       = 32'h0;
                w_dat_d       = 32'h0;
                w_rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q     <= ST_IDLE;
            r_cmd_ready_q <= 1'b1;
            r_busy_q      <= 1'b0;
            r_cyc_q       <= 1'b0;
            r_we_q        <= 1'b0;
            r_sel_q       <= 4'h0;
            r_adr_q       <= 32'h0;
            r_dat_q       <= 32'h0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_dat_q   <= 32'h0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cmd_ready_q <= w_cmd_ready_d;
            r_busy_q      <= w_busy_d;
            r_cyc_q       <= w_cyc_d;
            r_we_q        <= w_we_d;
            r_sel_q       <= w_sel_d;
            r_adr_q       <= w_adr_d;
            r_dat_q       <= w_dat_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_dat_q   <= w_rsp_dat_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    assign cmd_ready_o = r_cmd_ready_q;
    assign busy_o      = r_busy_q;
    assign wbm_cyc_o   = r_cyc_q;
    assign wbm_stb_o   = r_cyc_q;
    assign wbm_we_o    = r_we_q;
    assign wbm_sel_o   = r_sel_q;
    assign wbm_adr_o   = r_adr_q;
    assign wbm_dat_o   = r_dat_q;
    assign rsp_valid_o = r_rsp_valid_q;
    assign rsp_dat_o   = r_rsp_dat_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    assign rsp_err_o   = r_rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
    logic w_unused_err;
    assign w_unused_err = r_rsp_err_q;
`endif

endmodule : wb_initiator

`default_nettype wire

// File: tb/tb_wb_initiator.sv
// ============================================================================
// Module      : tb_wb_initiator
// Description : Directed self-checking bench for wb_initiator with a
//               transaction-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_initiator;

    localparam int TMO = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        busy_o;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy_o(busy_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, advanced per clock from the
    // inputs that the upcoming rising edge will sample.
    bit          m_ok = 1'b0;
    bit          m_bus, m_rsp, m_we, m_err;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat, m_rdat;
    int          m_bus_clks;

    int          cyc_num = 0;
    int          cyc_run = 0;
    int          last_cyc_len = 0;
    logic [31:0] cyc_dat = 32'h0;
    int          acc_q[$];

    always @(negedge clk) begin
        cyc_num++;
        if (m_ok) begin
            chk("m_cmd_ready", cmd_ready_o, !(m_bus || m_rsp));
            chk("m_busy",      busy_o,      (m_bus || m_rsp));
            chk("m_cyc",       wbm_cyc_o,   m_bus);
            chk("m_stb",       wbm_stb_o,   m_bus);
            chk("m_we",        wbm_we_o,    m_bus ? m_we  : 1'b0);
            chk("m_sel",       wbm_sel_o,   m_bus ? m_sel : 4'h0);
            chk("m_adr",       wbm_adr_o,   m_bus ? m_adr : 32'h0);
            chk("m_wdat",      wbm_dat_o,   m_bus ? m_dat : 32'h0);
            chk("m_rsp_valid", rsp_valid_o, m_rsp);
            if (m_rsp) begin
                chk("m_rsp_dat", rsp_dat_o, m_rdat);
                chk("m_rsp_err", rsp_err_o, m_err);
            end
        end
        if (wbm_cyc_o === 1'b1) begin
            cyc_run++;
            cyc_dat = wbm_dat_o;
        end else if (cyc_run > 0) begin
            last_cyc_len = cyc_run;
            cyc_run = 0;
        end
        if (cmd_valid_i && cmd_ready_o === 1'b1) acc_q.push_back(cyc_num);

        if (rst) begin
            m_ok = 1'b1; m_bus = 1'b0; m_rsp = 1'b0; m_err = 1'b0; m_rdat = 32'h0;
        end else if (m_ok) begin
            if (m_rsp) begin
                if (rsp_ready_i) m_rsp = 1'b0;
            end else if (m_bus) begin
                m_bus_clks++;
                if (wbm_ack_i) begin
                    m_bus = 1'b0; m_rsp = 1'b1; m_err = 1'b0;
                    m_rdat = m_we ? 32'h0 : wbm_dat_i;
                end else if (TMO_ON && m_bus_clks == TMO) begin
                    m_bus = 1'b0; m_rsp = 1'b1; m_err = 1'b1; m_rdat = 32'h0;
                end
            end else if (cmd_valid_i) begin
                m_bus = 1'b1; m_bus_clks = 0;
                m_we = cmd_we_i; m_adr = cmd_adr_i; m_dat = cmd_dat_i; m_sel = cmd_sel_i;
            end
        end
    end

    // Slave: acks after slv_ws wait states once cyc/stb is seen
    bit          slave_on = 1'b1;
    int          slv_ws = 0;
    int          slv_cnt = 0;
    logic [31:0] slv_rdata = 32'h0;

    assign wbm_dat_i = slv_rdata;

    always @(posedge clk) begin
        #1;
        if (!slave_on) begin
            slv_cnt = 0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            wbm_ack_i = (slv_cnt == slv_ws);
            slv_cnt++;
        end else begin
            wbm_ack_i = 1'b0;
            slv_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        bit done = 1'b0;
        step();
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = (cmd_ready_o === 1'b1);
            step();
        end
        cmd_valid_i = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    task automatic wait_rsp(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            got = (rsp_valid_o === 1'b1);
        end
        #1;
        chk("rsp_arrived", got, 1'b1);
    endtask

    task automatic consume();
        step();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 32'h0;
        cmd_dat_i = 32'h0; cmd_sel_i = 4'h0; rsp_ready_i = 1'b0; wbm_ack_i = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_cmd_ready", cmd_ready_o, 1'b1);
        chk("rst_busy",      busy_o,      1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_rsp_err",   rsp_err_o,   1'b0);
        chk("rst_rsp_dat",   rsp_dat_o,   32'h0);
        chk("rst_cyc",       wbm_cyc_o,   1'b0);
        chk("rst_adr",       wbm_adr_o,   32'h0);

        // Write, zero-wait slave
        slv_ws = 0;
        send(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF);
        wait_rsp(20);
        chk("wr_err",     rsp_err_o,    1'b0);
        chk("wr_rsp_dat", rsp_dat_o,    32'h0);
        chk("wr_cyc_len", last_cyc_len, 32'd1);
        chk("wr_bus_dat", cyc_dat,      32'h0000_00A5);
        consume();

        // Read, three wait states, response held back for five clocks
        slv_ws = 3; slv_rdata = 32'h1234_5678;
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        wait_rsp(20);
        chk("rd_dat",     rsp_dat_o,    32'h1234_5678);
        chk("rd_cyc_len", last_cyc_len, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_hold_valid", rsp_valid_o, 1'b1);
            chk("rd_hold_dat",   rsp_dat_o,   32'h1234_5678);
        end
        consume();

        // Back-to-back with cmd_valid held, sel of zero passed through
        slv_ws = 0; slv_rdata = 32'h0BAD_F00D;
        step();
        acc_q.delete();
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0040; cmd_sel_i = 4'h0;
        repeat (10) step();
        cmd_valid_i = 1'b0;
        repeat (5) step();
        rsp_ready_i = 1'b0;
        chk("b2b_count", (acc_q.size() >= 3), 1'b1);
        for (int i = 1; i < acc_q.size(); i++)
            chk("b2b_gap", acc_q[i] - acc_q[i-1], 32'd3);

`ifdef WB_INITIATOR_TIMEOUT_EN
        // Silent slave times out after TMO clocks
        slave_on = 1'b0;
        send(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        wait_rsp(30);
        chk("tmo_err",     rsp_err_o,    1'b1);
        chk("tmo_dat",     rsp_dat_o,    32'h0);
        chk("tmo_cyc_len", last_cyc_len, 32'd8);
        consume();
        // Ack on the terminal-count clock wins
        slave_on = 1'b1; slv_ws = 7; slv_rdata = 32'hCAFE_0001;
        send(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        wait_rsp(30);
        chk("tc_ack_err",     rsp_err_o,    1'b0);
        chk("tc_ack_dat",     rsp_dat_o,    32'hCAFE_0001);
        chk("tc_ack_cyc_len", last_cyc_len, 32'd8);
        consume();
`else
        // Without the watchdog the bus cycle waits for the slave indefinitely
        slave_on = 1'b0;
        send(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        repeat (20) step();
        @(negedge clk);
        chk("nt_cyc_held", wbm_cyc_o, 1'b1);
        step();
        slv_ws = 0; slv_rdata = 32'hCAFE_0001; slave_on = 1'b1;
        wait_rsp(20);
        chk("nt_err", rsp_err_o, 1'b0);
        chk("nt_dat", rsp_dat_o, 32'hCAFE_0001);
        consume();
`endif

        // Reset on the second BUS clock
        slave_on = 1'b0;
        send(1'b1, 32'h3000_0010, 32'h0000_0055, 4'h3);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_cyc_before", wbm_cyc_o, 1'b1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_cyc",       wbm_cyc_o,   1'b0);
        chk("rmid_stb",       wbm_stb_o,   1'b0);
        chk("rmid_rsp_valid", rsp_valid_o, 1'b0);
        chk("rmid_cmd_ready", cmd_ready_o, 1'b1);
        repeat (5) step();

        // Stray ack while idle
        step();
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        @(negedge clk);
        chk("stray_busy",      busy_o,      1'b0);
        chk("stray_rsp_valid", rsp_valid_o, 1'b0);
        chk("stray_cmd_ready", cmd_ready_o, 1'b1);
        repeat (3) step();
        slave_on = 1'b1;

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_wb_initiator

`default_nettype wire
